// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared shift-add multiplier.
// Owns the sequencing; the shift register and accumulator live outside.
module mult_arbiter #(
  parameter int BW = 5,
  localparam int PW = 8 + BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [7:0]    a0,
  input  logic [7:0]    a1,
  input  logic [BW-1:0] b0,
  input  logic [BW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [PW-1:0] p0,
  output logic [PW-1:0] p1,
  output logic          busy,
  output logic [1:0]    sr_sel,
  output logic [PW-1:0] sr_d,
  output logic          acc_ld,
  output logic          acc_clr,
  input  logic [PW-1:0] acc_q
);

  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] CLAST = CW'(BW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MUL,
    DONE
  } state_t;

  state_t        st;
  state_t        st_n;
  logic          own;
  logic          last;
  logic [7:0]    aq;
  logic [BW-1:0] bq;
  logic [CW-1:0] cnt;
  logic          elig0;
  logic          elig1;
  logic          pick;

  // A requester is not re-granted during its own done pulse.
  assign elig0 = req0 & ~done0;
  assign elig1 = req1 & ~done1;
  assign pick  = (elig0 & elig1) ? ~last : elig1;

  assign busy = (st != IDLE);
  assign gnt0 = busy & ~own;
  assign gnt1 = busy & own;
  assign sr_d = {{BW{1'b0}}, aq};

  always_comb begin
    st_n    = st;
    sr_sel  = 2'b00;
    acc_ld  = 1'b0;
    acc_clr = 1'b0;
    unique case (st)
      IDLE: begin
        if (elig0 | elig1)
          st_n = LOAD;
      end
      LOAD: begin
        sr_sel  = 2'b01;
        acc_clr = 1'b1;
        st_n    = MUL;
      end
      MUL: begin
        sr_sel = 2'b10;
        acc_ld = bq[0];
        if (cnt == CLAST)
          st_n = DONE;
      end
      DONE: begin
        st_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
      aq    <= '0;
      bq    <= '0;
      cnt   <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      p0    <= '0;
      p1    <= '0;
    end else begin
      st    <= st_n;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (st)
        IDLE: begin
          if (elig0 | elig1) begin
            own <= pick;
            aq  <= pick ? a1 : a0;
            bq  <= pick ? b1 : b0;
          end
        end
        LOAD: begin
          cnt <= '0;
        end
        MUL: begin
          bq  <= bq >> 1;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          last <= own;
          if (own) begin
            p1    <= acc_q;
            done1 <= 1'b1;
          end else begin
            p0    <= acc_q;
            done0 <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: external shift register/accumulator plus
// a transaction-timed reference model checked every cycle.
module tb_mult_arbiter;

  localparam int BW = 5;
  localparam int PW = 8 + BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [7:0]    a0 = '0;
  logic [7:0]    a1 = '0;
  logic [BW-1:0] b0 = '0;
  logic [BW-1:0] b1 = '0;
  logic          gnt0, gnt1, done0, done1, busy;
  logic          acc_ld, acc_clr;
  logic [1:0]    sr_sel;
  logic [PW-1:0] p0, p1, sr_d;
  logic [PW-1:0] sr, acc;

  int n_chk = 0;
  int n_err = 0;

  mult_arbiter #(.BW(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .p0(p0), .p1(p1), .busy(busy),
    .sr_sel(sr_sel), .sr_d(sr_d),
    .acc_ld(acc_ld), .acc_clr(acc_clr),
    .acc_q(acc)
  );

  always #5 clk = ~clk;

  // external datapath the arbiter steers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      acc <= '0;
    end else begin
      if (sr_sel == 2'b01) sr <= sr_d;
      else if (sr_sel == 2'b10) sr <= sr << 1;
      if (acc_clr) acc <= '0;
      else if (acc_ld) acc <= acc + sr;
    end
  end

  // reference model: one job in flight, counted in edges to completion
  bit            m_act;
  bit            m_own;
  bit            m_last;
  int            m_left;
  logic [7:0]    m_a;
  logic [BW-1:0] m_b;
  logic [PW-1:0] m_p [2];
  bit            m_done [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0;
    m_last = 1;
    m_left = 0;
    m_p[0] = '0;
    m_p[1] = '0;
    m_done[0] = 0;
    m_done[1] = 0;
  endtask

  task automatic model_edge();
    bit nd0, nd1, e0, e1;
    nd0 = 0;
    nd1 = 0;
    if (m_act) begin
      m_left--;
      if (m_left == 0) begin
        m_p[m_own] = PW'(32'(m_a) * 32'(m_b));
        if (m_own) nd1 = 1;
        else nd0 = 1;
        m_last = m_own;
        m_act = 0;
      end
    end else begin
      e0 = req0 && !m_done[0];
      e1 = req1 && !m_done[1];
      if (e0 || e1) begin
        m_own = (e0 && e1) ? !m_last : e1;
        m_a = m_own ? a1 : a0;
        m_b = m_own ? b1 : b0;
        m_left = BW + 2;
        m_act = 1;
      end
    end
    m_done[0] = nd0;
    m_done[1] = nd1;
  endtask

  task automatic check_outs();
    logic [3:0] ectl;
    ectl = 4'b0000;
    if (m_act) begin
      if (m_left == BW + 2) ectl = 4'b0101;
      else if (m_left >= 2) ectl = {2'b10, m_b[BW + 1 - m_left], 1'b0};
    end
    chk("gnt", {gnt1, gnt0}, {m_act && m_own, m_act && !m_own});
    chk("done", {done1, done0}, {m_done[1], m_done[0]});
    chk("p0", p0, m_p[0]);
    chk("p1", p1, m_p[1]);
    chk("busy", busy, m_act);
    chk("ctl", {sr_sel, acc_ld, acc_clr}, ectl);
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_in(input bit r0, input bit r1,
                        input int x0, input int y0,
                        input int x1, input int y1);
    req0 = r0;
    req1 = r1;
    a0 = 8'(x0);
    b0 = BW'(y0);
    a1 = 8'(x1);
    b1 = BW'(y1);
  endtask

  task automatic wait_done(input bit k, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(k ? done1 : done0) && lat < 40);
  endtask

  int lat;

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single request, full-range multiplier
    set_in(1, 0, 200, 31, 0, 0);
    wait_done(0, lat);
    chk("lat_a", lat, BW + 3);
    chk("p_6200", p0, 6200);
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // zero multiplier still runs all MUL cycles
    set_in(0, 1, 0, 0, 255, 0);
    wait_done(1, lat);
    chk("lat_b0", lat, BW + 3);
    chk("p_zero", p1, 0);
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // tie from reset goes to requester 0
    rst_n = 1'b0;
    repeat (2) step();
    set_in(1, 1, 3, 5, 7, 9);
    rst_n = 1'b1;
    wait_done(0, lat);
    chk("tie_lat", lat, BW + 3);
    chk("p_15", p0, 15);
    req0 = 1'b0;
    wait_done(1, lat);
    chk("second_lat", lat, BW + 3);
    chk("p_63", p1, 63);
    req1 = 1'b0;
    step();

    // both held: completions alternate 0,1,0,1
    set_in(1, 1, 11, 13, 17, 19);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'(i % 2), lat);
      chk("alt", {done1, done0}, (i % 2) ? 2 : 1);
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2 * BW + 6) step();

    // reset during the third MUL cycle aborts the job
    set_in(1, 0, 10, 10, 0, 0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("abort_p0", p0, 0);
    chk("abort_done", done0, 0);
    rst_n = 1'b1;
    wait_done(0, lat);
    chk("p_100", p0, 100);
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // operand change after grant is ignored
    set_in(1, 0, 4, 6, 0, 0);
    step();
    a0 = 8'd9;
    b0 = BW'(3);
    wait_done(0, lat);
    chk("p_24", p0, 24);
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // randomized traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      b0 = BW'($urandom);
      b1 = BW'($urandom);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
